// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: a PC register prefetches into a small instruction queue
// that decode drains over valid/ready; a redirect flushes the queue and restarts fetch.
module fetch_queue_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        fetch_en,
    output logic [XLEN-1:0]             imem_addr,
    input  logic [31:0]                 imem_data,
    input  logic                        redirect,
    input  logic [XLEN-1:0]             redirect_base,
    input  logic [XLEN-1:0]             redirect_offset,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_instr,
    output logic [XLEN-1:0]             out_pc,
    output logic [$clog2(QDEPTH):0]     q_count
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pc_mem    [QDEPTH];
    logic [31:0]     instr_mem [QDEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic            push;
    logic            pop;
    logic [XLEN-1:0] target_sum;
    logic [XLEN-1:0] target;

    // Redirect targets are word aligned by clearing the two low address bits.
    assign target_sum = redirect_base + redirect_offset;
    assign target     = target_sum & ~XLEN'(3);

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready & ~redirect;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push      = fetch_en & ~redirect & ((count < CW'(QDEPTH)) | pop);

    assign imem_addr = fetch_pc;
    assign q_count   = count;
    assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;
    assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= target;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PW'(1);
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: queue storage is deliberately not reset; an entry is only read
    // after it has been written, and leaving it out keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= imem_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: memory returns word = address, and a
// scoreboard of expected queue PCs is checked against the head every cycle.
module tb_fetch_queue_unit;

    localparam int              XLEN     = 32;
    localparam int              QDEPTH   = 4;
    localparam logic [31:0]     RESET_PC = 32'h0;

    logic              clk = 1'b0;
    logic              reset;
    logic              fetch_en;
    logic [XLEN-1:0]   imem_addr;
    logic [31:0]       imem_data;
    logic              redirect;
    logic [XLEN-1:0]   redirect_base;
    logic [XLEN-1:0]   redirect_offset;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [XLEN-1:0]   out_pc;
    logic [$clog2(QDEPTH):0] q_count;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    logic [31:0] sb [$];
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    assign imem_data = imem_addr;

    fetch_queue_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_en        (fetch_en),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .redirect        (redirect),
        .redirect_base   (redirect_base),
        .redirect_offset (redirect_offset),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .q_count         (q_count)
    );

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock: check head against the model, advance the model, then check state.
    task automatic step();
        logic xfer;
        logic push;
        int   n;
        n = sb.size();
        chk("out_valid", 64'(out_valid), 64'(n != 0));
        if (n != 0) begin
            chk("head_pc",    64'(out_pc),    64'(sb[0]));
            chk("head_instr", 64'(out_instr), 64'(sb[0]));
        end else begin
            chk("idle_pc",    64'(out_pc),    64'h0);
            chk("idle_instr", 64'(out_instr), 64'h0);
        end
        xfer = reset && !redirect && out_ready && (n != 0);
        push = reset && fetch_en && !redirect && ((n < QDEPTH) || xfer);
        if (!reset) begin
            sb.delete();
            m_pc = RESET_PC;
        end else if (redirect) begin
            sb.delete();
            m_pc = (redirect_base + redirect_offset) & ~32'h3;
        end else begin
            if (xfer) void'(sb.pop_front());
            if (push) begin
                sb.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("q_count",   64'(q_count),   64'(sb.size()));
        chk("imem_addr", 64'(imem_addr), 64'(m_pc));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    logic [31:0] held_pc;

    initial begin
        reset = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
        redirect = 1'b0; redirect_base = '0; redirect_offset = '0;
        @(negedge clk);
        @(negedge clk);
        m_pc = RESET_PC;
        chk("rst_q_count",   64'(q_count),   64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_pc",    64'(out_pc),    64'h0);
        chk("rst_out_instr", 64'(out_instr), 64'h0);
        chk("rst_imem_addr", 64'(imem_addr), 64'(RESET_PC));

        // Streaming with decode always ready: one instruction per cycle, q_count 1.
        reset = 1'b1;
        steps(6);
        chk("stream_q_count", 64'(q_count), 64'h1);

        // Backpressure from a fresh reset: fills to QDEPTH, then drains back-to-back.
        reset = 1'b0; step(); reset = 1'b1;
        out_ready = 1'b0;
        steps(6);
        chk("bp_full",      64'(q_count),   64'd4);
        chk("bp_addr_hold", 64'(imem_addr), 64'h10);
        out_ready = 1'b1;
        steps(6);

        // Redirect while full: head 0x0 is discarded, fetch restarts at 0x100-8.
        reset = 1'b0; step(); reset = 1'b1;
        out_ready = 1'b0;
        steps(5);
        chk("rd_full", 64'(q_count), 64'd4);
        out_ready = 1'b1; redirect = 1'b1;
        redirect_base = 32'h100; redirect_offset = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        chk("rd_valid_drop", 64'(out_valid), 64'h0);
        chk("rd_target",     64'(imem_addr), 64'hF8);
        step();
        chk("rd_first_pc", 64'(out_pc), 64'hF8);
        steps(3);

        // Misaligned target is forced down to a word boundary.
        redirect = 1'b1; redirect_base = 32'h13; redirect_offset = 32'h0;
        step();
        redirect = 1'b0;
        chk("align_addr", 64'(imem_addr), 64'h10);
        steps(3);

        // Fetch address wraps from the top of the address space to zero.
        redirect = 1'b1; redirect_base = 32'hFFFF_FFF0; redirect_offset = 32'hC;
        step();
        redirect = 1'b0;
        step();
        chk("wrap_pc0", 64'(out_pc), 64'hFFFF_FFFC);
        step();
        chk("wrap_pc1", 64'(out_pc), 64'h0);
        steps(2);

        // Fetch disabled: queue drains, PC holds, then resumes from the held PC.
        out_ready = 1'b0;
        steps(2);
        out_ready = 1'b1; fetch_en = 1'b0;
        held_pc = imem_addr;
        steps(3);
        chk("fe_drained", 64'(q_count),   64'h0);
        chk("fe_hold",    64'(imem_addr), 64'(held_pc));
        fetch_en = 1'b1;
        step();
        chk("fe_resume", 64'(out_pc), 64'(held_pc));
        steps(3);

        // Reset mid-stream at occupancy 3 wins over a simultaneous redirect.
        out_ready = 1'b0;
        steps(2);
        chk("mid_occ", 64'(q_count), 64'd3);
        reset = 1'b0; redirect = 1'b1; redirect_base = 32'h400; redirect_offset = 32'h0;
        step();
        reset = 1'b1; redirect = 1'b0;
        chk("mid_rst_count", 64'(q_count),   64'h0);
        chk("mid_rst_valid", 64'(out_valid), 64'h0);
        chk("mid_rst_pc",    64'(out_pc),    64'h0);
        chk("mid_rst_addr",  64'(imem_addr), 64'(RESET_PC));
        out_ready = 1'b1;
        steps(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
